// File: rtl/vdot_unit.sv
// ============================================================================
// Module   : vdot_unit
// Brief    : Sequential signed vector dot-product engine, one lane per clock,
//            with a saturated W-bit result and an overflow flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vdot_unit #(
    parameter int LANES = 16,
    parameter int W     = 16
) (
    input  logic                 Clk1,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [LANES*W-1:0]   VecA,
    input  logic [LANES*W-1:0]   VecB,
    output logic                 Busy,
    output logic                 Done,
    output logic [W-1:0]         Result,
    output logic                 V
);

    localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int ACCW = 2 * W + LW;
    localparam logic [LW-1:0] C_LAST = LW'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_accept;
    logic   w_last;

    logic signed [W-1:0] r_a [LANES];
    logic signed [W-1:0] r_b [LANES];
    logic [LW-1:0]       r_lane;
    logic [ACCW-1:0]     r_acc;

    logic signed [W-1:0]   w_a;
    logic signed [W-1:0]   w_b;
    logic signed [2*W-1:0] w_prod;
    logic [ACCW-1:0]       w_sum;
    logic                  w_pos_ovf;
    logic                  w_neg_ovf;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clk1 or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_last   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_accept = 1'b1;
                    w_next   = S_MAC;
                end
            end
            S_MAC: begin
                if (r_lane == C_LAST) begin
                    w_last = 1'b1;
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                // Start in the Done cycle chains straight into the next op.
                if (Start) begin
                    w_accept = 1'b1;
                    w_next   = S_MAC;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign Busy = (r_state == S_MAC);
    assign Done = (r_state == S_DONE);

    // ------------------------------------------------------------------
    // Multiply-accumulate datapath
    // ------------------------------------------------------------------
    assign w_a    = r_a[r_lane];
    assign w_b    = r_b[r_lane];
    assign w_prod = w_a * w_b;
    assign w_sum  = r_acc + {{LW{w_prod[2*W-1]}}, w_prod};

    // Fits in W-bit signed only if bits [ACCW-1:W-1] are all equal.
    assign w_pos_ovf = ~w_sum[ACCW-1] &  (|w_sum[ACCW-2:W-1]);
    assign w_neg_ovf =  w_sum[ACCW-1] & ~(&w_sum[ACCW-2:W-1]);

    always_ff @(posedge Clk1 or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < LANES; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
            end
            r_lane <= '0;
            r_acc  <= '0;
            Result <= '0;
            V      <= 1'b0;
        end else if (w_accept) begin
            for (int i = 0; i < LANES; i++) begin
                r_a[i] <= VecA[i*W +: W];
                r_b[i] <= VecB[i*W +: W];
            end
            r_lane <= '0;
            r_acc  <= '0;
        end else if (r_state == S_MAC) begin
            r_acc  <= w_sum;
            r_lane <= r_lane + 1'b1;
            if (w_last) begin
                if (w_pos_ovf) begin
                    Result <= {1'b0, {(W-1){1'b1}}};
                    V      <= 1'b1;
                end else if (w_neg_ovf) begin
                    Result <= {1'b1, {(W-1){1'b0}}};
                    V      <= 1'b1;
                end else begin
                    Result <= w_sum[W-1:0];
                    V      <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vdot_unit.sv
// ============================================================================
// Module   : tb_vdot_unit
// Brief    : Directed plus randomized bench for vdot_unit against a plain
//            integer dot-product reference with saturation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vdot_unit;

    localparam int LANES = 16;
    localparam int W     = 16;
    localparam int VW    = LANES * W;

    logic          Clk1;
    logic          Reset;
    logic          Start;
    logic [VW-1:0] VecA;
    logic [VW-1:0] VecB;
    logic          Busy;
    logic          Done;
    logic [W-1:0]  Result;
    logic          V;

    int ncmp  = 0;
    int nfail = 0;

    logic [W-1:0] exp_res;
    logic         exp_v;

    vdot_unit #(.LANES(LANES), .W(W)) dut (
        .Clk1   (Clk1),
        .Reset  (Reset),
        .Start  (Start),
        .VecA   (VecA),
        .VecB   (VecB),
        .Busy   (Busy),
        .Done   (Done),
        .Result (Result),
        .V      (V)
    );

    initial Clk1 = 1'b0;
    always #5 Clk1 = ~Clk1;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer dot product, then clamp to W-bit signed.
    function automatic logic [W:0] ref_dot(input logic [VW-1:0] a, input logic [VW-1:0] b);
        longint s;
        longint x;
        longint y;
        s = 0;
        for (int i = 0; i < LANES; i++) begin
            x = longint'($signed(a[i*W +: W]));
            y = longint'($signed(b[i*W +: W]));
            s += x * y;
        end
        if (s > 32767)       return {1'b1, 16'h7FFF};
        else if (s < -32768) return {1'b1, 16'h8000};
        else                 return {1'b0, s[15:0]};
    endfunction

    function automatic logic [VW-1:0] rand_vec(input int mag);
        logic [VW-1:0] v;
        int r;
        for (int i = 0; i < LANES; i++) begin
            r = int'($urandom_range(2 * mag)) - mag;
            v[i*W +: W] = r[15:0];
        end
        return v;
    endfunction

    function automatic logic [VW-1:0] fill(input logic [W-1:0] x);
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*W +: W] = x;
        return v;
    endfunction

    // Counts negedges until Done; optionally pulses Start with junk operands.
    task automatic wait_done(input int pulse_at, output int n);
        n = 0;
        while (!Done && n < 40) begin
            @(negedge Clk1);
            n++;
            Start = (n == pulse_at);
            if (n == pulse_at) begin
                VecA = rand_vec(32768);
                VecB = rand_vec(32768);
            end
            check("busy_done_exclusive", {31'd0, Busy & Done}, 32'd0);
            if (n == 3) begin
                check("result_hold_mac", {16'd0, Result}, {16'd0, exp_res});
                check("v_hold_mac", {31'd0, V}, {31'd0, exp_v});
            end
        end
        Start = 1'b0;
    endtask

    task automatic run_op(input logic [VW-1:0] a, input logic [VW-1:0] b,
                          input int pulse_at, input string tag);
        logic [W:0] e;
        int n;
        e = ref_dot(a, b);
        @(negedge Clk1);
        Start = 1'b1; VecA = a; VecB = b;
        @(negedge Clk1);
        Start = 1'b0; VecA = rand_vec(32768); VecB = rand_vec(32768);
        check({tag, "_busy"}, {31'd0, Busy}, 32'd1);
        wait_done(pulse_at, n);
        exp_res = e[W-1:0];
        exp_v   = e[W];
        check({tag, "_latency"}, n, 32'd16);
        check({tag, "_result"}, {16'd0, Result}, {16'd0, exp_res});
        check({tag, "_v"}, {31'd0, V}, {31'd0, exp_v});
        check({tag, "_busy_at_done"}, {31'd0, Busy}, 32'd0);
        @(negedge Clk1);
        check({tag, "_done_single"}, {31'd0, Done}, 32'd0);
        check({tag, "_idle"}, {31'd0, Busy}, 32'd0);
        check({tag, "_result_hold"}, {16'd0, Result}, {16'd0, exp_res});
    endtask

    logic [VW-1:0] va;
    logic [VW-1:0] vb;
    logic [W:0]    e2;
    int            n1;
    int            ndone;

    initial begin
        Reset = 1'b1; Start = 1'b0; VecA = '0; VecB = '0;
        exp_res = '0; exp_v = 1'b0;
        repeat (2) @(negedge Clk1);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_result", {16'd0, Result}, 32'd0);
        check("rst_v", {31'd0, V}, 32'd0);
        Reset = 1'b0;
        @(negedge Clk1);
        check("idle_busy", {31'd0, Busy}, 32'd0);

        run_op(fill(16'd1), fill(16'd1), -1, "ones");
        check("ones_value", {16'd0, exp_res}, 32'h10);

        for (int i = 0; i < LANES; i++) begin
            va[i*W +: W] = (i % 2 == 0) ? 16'd100 : -16'sd100;
            vb[i*W +: W] = 16'd3;
        end
        run_op(va, vb, -1, "alt");
        for (int i = 0; i < LANES; i++) va[i*W +: W] = 16'(i);
        run_op(va, fill(16'd2), -1, "index");
        check("index_value", {16'd0, exp_res}, 32'd240);

        run_op(fill(16'h7FFF), fill(16'h7FFF), -1, "sat_pos");
        check("sat_pos_value", {15'd0, exp_v, exp_res}, 32'h17FFF);
        run_op(fill(16'h8000), fill(16'h7FFF), -1, "sat_neg");
        check("sat_neg_value", {15'd0, exp_v, exp_res}, 32'h18000);
        run_op(fill(16'd1), fill(16'd1), -1, "v_clear");

        run_op(rand_vec(300), rand_vec(300), 5, "start_in_mac");

        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) run_op(rand_vec(400), rand_vec(400), -1, "rand_small");
            else            run_op(rand_vec(32768), rand_vec(32768), -1, "rand_full");
        end

        // Reset in the middle of MAC: abandon with no Done.
        @(negedge Clk1);
        Start = 1'b1; VecA = fill(16'd5); VecB = fill(16'd5);
        @(negedge Clk1);
        Start = 1'b0;
        repeat (8) @(negedge Clk1);
        Reset = 1'b1;
        #1;
        check("midrst_busy", {31'd0, Busy}, 32'd0);
        check("midrst_done", {31'd0, Done}, 32'd0);
        check("midrst_result", {16'd0, Result}, 32'd0);
        check("midrst_v", {31'd0, V}, 32'd0);
        exp_res = '0; exp_v = 1'b0;
        @(negedge Clk1);
        Reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk1);
            if (Done) ndone++;
        end
        check("midrst_no_done", ndone, 32'd0);
        check("midrst_idle", {31'd0, Busy}, 32'd0);
        run_op(fill(16'd1), fill(16'd1), -1, "after_rst");

        // Back-to-back: Start high in the Done cycle.
        va = rand_vec(250); vb = rand_vec(250);
        @(negedge Clk1);
        Start = 1'b1; VecA = va; VecB = vb;
        @(negedge Clk1);
        Start = 1'b0;
        wait_done(-1, n1);
        e2 = ref_dot(va, vb);
        exp_res = e2[W-1:0]; exp_v = e2[W];
        check("b2b_first_latency", n1, 32'd16);
        check("b2b_first_result", {15'd0, V, Result}, {15'd0, exp_v, exp_res});
        va = rand_vec(250); vb = rand_vec(250);
        Start = 1'b1; VecA = va; VecB = vb;
        @(negedge Clk1);
        Start = 1'b0; VecA = '0; VecB = '0;
        check("b2b_second_accept", {31'd0, Busy}, 32'd1);
        wait_done(-1, n1);
        e2 = ref_dot(va, vb);
        exp_res = e2[W-1:0]; exp_v = e2[W];
        check("b2b_spacing", n1 + 1, 32'd17);
        check("b2b_second_result", {15'd0, V, Result}, {15'd0, exp_v, exp_res});

        repeat (2) @(negedge Clk1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

`default_nettype wire
